packet_dma_writer: RTL and testbench



---
 rtl/packet_dma_writer.sv | 142 ++++++++++++++
 tb/tb_packet_dma_writer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_dma_writer.sv
// Packs a byte-packet stream (4-byte little-endian address header, then payload)
// into 32-bit little-endian memory writes with byte strobes on a valid/ready port.
module packet_dma_writer (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        mem_write_valid,
  input  logic        mem_write_ready,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_strobe,
  output logic        packet_done,
  output logic        packet_error
);

  typedef enum logic [1:0] {
    ST_ADDR  = 2'd0,
    ST_DATA  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  hdr_idx_q, hdr_idx_d;
  logic [23:0] hdr_q, hdr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  strb_q, strb_d;
  logic [1:0]  lane_q, lane_d;
  logic        last_seen_q, last_seen_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        accept;

  // Ready depends only on state, so there is no path from in_valid or mem_write_ready.
  assign in_ready         = (state_q != ST_WRITE);
  assign accept           = in_valid & in_ready;
  assign mem_write_valid  = (state_q == ST_WRITE);
  assign mem_address      = addr_q;
  assign mem_write_data   = data_q;
  assign mem_write_strobe = strb_q;
  assign packet_done      = done_q;
  assign packet_error     = error_q;

  always_comb begin
    // NOTE: every _d gets a default before the case, so no path can infer a latch.
    state_d     = state_q;
    hdr_idx_d   = hdr_idx_q;
    hdr_d       = hdr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    strb_d      = strb_q;
    lane_d      = lane_q;
    last_seen_d = last_seen_q;
    done_d      = 1'b0;
    error_d     = 1'b0;

    case (state_q)
      ST_ADDR: begin
        if (accept) begin
          if (hdr_idx_q == 2'd3) begin
            hdr_idx_d = 2'd0;
            if (in_last) begin
              done_d = 1'b1;
            end else begin
              addr_d  = {in_data, hdr_q[23:2], 2'b00};
              lane_d  = 2'd0;
              state_d = ST_DATA;
            end
          end else if (in_last) begin
            error_d   = 1'b1;
            hdr_idx_d = 2'd0;
          end else begin
            hdr_d[{hdr_idx_q, 3'b000} +: 8] = in_data;
            hdr_idx_d = hdr_idx_q + 2'd1;
          end
        end
      end

      ST_DATA: begin
        if (accept) begin
          data_d[{lane_q, 3'b000} +: 8] = in_data;
          strb_d[lane_q]                = 1'b1;
          lane_d                        = lane_q + 2'd1;
          if ((lane_q == 2'd3) || in_last) begin
            last_seen_d = in_last;
            state_d     = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        if (mem_write_ready) begin
          data_d = 32'd0;
          strb_d = 4'd0;
          lane_d = 2'd0;
          if (last_seen_q) begin
            done_d  = 1'b1;
            state_d = ST_ADDR;
          end else begin
            // Address wraps modulo 2^32 after 0xFFFFFFFC.
            addr_d  = addr_q + 32'd4;
            state_d = ST_DATA;
          end
        end
      end

      default: state_d = ST_ADDR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= ST_ADDR;
      hdr_idx_q   <= 2'd0;
      hdr_q       <= 24'd0;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      strb_q      <= 4'd0;
      lane_q      <= 2'd0;
      last_seen_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_idx_q   <= hdr_idx_d;
      hdr_q       <= hdr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      strb_q      <= strb_d;
      lane_q      <= lane_d;
      last_seen_q <= last_seen_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: tb/tb_packet_dma_writer.sv
// Scoreboard bench for packet_dma_writer: directed packets push expected writes and
// done/error pulses into a queue; a monitor pops and compares as the DUT produces them.
module tb_packet_dma_writer;

  logic        clock;
  logic        clear_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        mem_write_valid;
  logic        mem_write_ready;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_strobe;
  logic        packet_done;
  logic        packet_error;

  packet_dma_writer dut (
    .clock            (clock),
    .clear_n          (clear_n),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_last          (in_last),
    .in_ready         (in_ready),
    .mem_write_valid  (mem_write_valid),
    .mem_write_ready  (mem_write_ready),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_strobe (mem_write_strobe),
    .packet_done      (packet_done),
    .packet_error     (packet_error)
  );

  localparam int K_WRITE = 0;
  localparam int K_DONE  = 1;
  localparam int K_ERROR = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;

  exp_t sb[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    e.kind = K_WRITE; e.addr = a; e.data = d; e.strb = s;
    sb.push_back(e);
  endtask

  task automatic push_event(input int k);
    exp_t e;
    e.kind = k; e.addr = 32'd0; e.data = 32'd0; e.strb = 4'd0;
    sb.push_back(e);
  endtask

  task automatic observe(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL unexpected_event: got kind %0d, expected nothing at %0t", kind, $time);
    end else begin
      e = sb.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == K_WRITE && e.kind == K_WRITE) begin
        check("write_addr", mem_address, e.addr);
        check("write_data", mem_write_data, e.data);
        check("write_strb", {28'd0, mem_write_strobe}, {28'd0, e.strb});
      end
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (clear_n) begin
      if (packet_done)  observe(K_DONE);
      if (packet_error) observe(K_ERROR);
      if (mem_write_valid && mem_write_ready) observe(K_WRITE);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input logic last);
    logic ok;
    int   waited;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    waited   = 0;
    forever begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock);
      #1;
      if (ok) break;
      waited++;
      if (waited > 40) begin
        n_compared++;
        n_mismatched++;
        $display("FAIL byte_timeout: got no in_ready, expected acceptance of 0x%02h", b);
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Bytes are given as a concatenation; the first byte sent is the leftmost one.
  task automatic send_bytes(input logic [127:0] bytes, input int n, input logic last);
    for (int i = 0; i < n; i++)
      send_byte(bytes[8*(n-1-i) +: 8], last && (i == n - 1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_valid"},    {31'd0, mem_write_valid}, 32'd0);
    check({tag, "_done"},     {31'd0, packet_done}, 32'd0);
    check({tag, "_error"},    {31'd0, packet_error}, 32'd0);
    check({tag, "_addr"},     mem_address, 32'd0);
    check({tag, "_data"},     mem_write_data, 32'd0);
    check({tag, "_strb"},     {28'd0, mem_write_strobe}, 32'd0);
  endtask

  initial begin
    clear_n         = 1'b1;
    in_valid        = 1'b0;
    in_data         = 8'd0;
    in_last         = 1'b0;
    mem_write_ready = 1'b1;
    #2 clear_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clock);
    #1 clear_n = 1'b1;

    // Two full words.
    push_write(32'h0000_1000, 32'h4433_2211, 4'b1111);
    push_write(32'h0000_1004, 32'h8877_6655, 4'b1111);
    push_event(K_DONE);
    send_bytes({8'h00, 8'h10, 8'h00, 8'h00}, 4, 1'b0);
    send_bytes({8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88}, 8, 1'b1);
    repeat (3) @(posedge clock); #1;

    // Unaligned header, two-byte payload.
    push_write(32'h0000_2000, 32'h0000_BBAA, 4'b0011);
    push_event(K_DONE);
    send_bytes({8'h03, 8'h20, 8'h00, 8'h00}, 4, 1'b0);
    send_bytes({8'hAA, 8'hBB}, 2, 1'b1);
    repeat (3) @(posedge clock); #1;

    // Address wrap.
    push_write(32'hFFFF_FFFC, 32'h0403_0201, 4'b1111);
    push_write(32'h0000_0000, 32'h0807_0605, 4'b1111);
    push_event(K_DONE);
    send_bytes({8'hFC, 8'hFF, 8'hFF, 8'hFF}, 4, 1'b0);
    send_bytes({8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}, 8, 1'b1);
    repeat (3) @(posedge clock); #1;

    // Truncated header, then a normal one-byte packet.
    push_event(K_ERROR);
    send_bytes({8'h00, 8'h30}, 2, 1'b1);
    push_write(32'h0000_3000, 32'h0000_005A, 4'b0001);
    push_event(K_DONE);
    send_bytes({8'h00, 8'h30, 8'h00, 8'h00}, 4, 1'b0);
    send_byte(8'h5A, 1'b1);
    repeat (3) @(posedge clock); #1;

    // Empty packet and three-byte partial word.
    push_event(K_DONE);
    send_bytes({8'h00, 8'h40, 8'h00, 8'h00}, 4, 1'b1);
    push_write(32'h0000_5000, 32'h0003_0201, 4'b0111);
    push_event(K_DONE);
    send_bytes({8'h00, 8'h50, 8'h00, 8'h00}, 4, 1'b0);
    send_bytes({8'h01, 8'h02, 8'h03}, 3, 1'b1);
    repeat (3) @(posedge clock); #1;

    // Back-pressure for 10 cycles on the first write.
    push_write(32'h0000_1000, 32'h4433_2211, 4'b1111);
    push_write(32'h0000_1004, 32'h8877_6655, 4'b1111);
    push_event(K_DONE);
    mem_write_ready = 1'b0;
    send_bytes({8'h00, 8'h10, 8'h00, 8'h00}, 4, 1'b0);
    send_bytes({8'h11, 8'h22, 8'h33, 8'h44}, 4, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check("stall_valid",    {31'd0, mem_write_valid}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_addr",     mem_address, 32'h0000_1000);
      check("stall_data",     mem_write_data, 32'h4433_2211);
      check("stall_strb",     {28'd0, mem_write_strobe}, 32'hF);
    end
    @(posedge clock); #1;
    mem_write_ready = 1'b1;
    send_bytes({8'h55, 8'h66, 8'h77, 8'h88}, 4, 1'b1);
    repeat (3) @(posedge clock); #1;

    // Reset while a write is pending, with ready raised in the same cycle.
    mem_write_ready = 1'b0;
    send_bytes({8'h00, 8'h70, 8'h00, 8'h00}, 4, 1'b0);
    send_bytes({8'h01, 8'h02, 8'h03, 8'h04}, 4, 1'b0);
    @(negedge clock);
    check("prereset_valid", {31'd0, mem_write_valid}, 32'd1);
    @(posedge clock); #1;
    clear_n         = 1'b0;
    mem_write_ready = 1'b1;
    #1 check_reset_outputs("midreset");
    @(posedge clock); #1;
    clear_n = 1'b1;
    push_write(32'h0000_6000, 32'hF0DE_BC9A, 4'b1111);
    push_event(K_DONE);
    send_bytes({8'h00, 8'h60, 8'h00, 8'h00}, 4, 1'b0);
    send_bytes({8'h9A, 8'hBC, 8'hDE, 8'hF0}, 4, 1'b1);

    repeat (5) @(posedge clock); #1;
    check("scoreboard_left", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
